// File: rtl/button_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : button_ctrl
// Description : Four-button front-end. Locks onto the highest-priority
//               pressed button and classifies the press as short, long or
//               auto-repeat. Events are presented through a one-entry
//               valid/ready output buffer. A display-mode index is stepped
//               by the events.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous reset, active low
//   button_i     in   4  debounced button levels, 1 = pressed, bit 0 wins
//   event_ready  in   1  consumer accepts the buffered event
//   event_valid  out  1  an event is held in the output buffer
//   event_id     out  2  button index that produced the event
//   event_long   out  1  1 = long/repeat event, 0 = short press
//   event_drop   out  1  one-cycle pulse: new event lost, buffer full
//   mode_o       out  3  display mode index, 0..MODE_COUNT-1
// ============================================================================
module button_ctrl #(
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int MODE_COUNT    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] button_i,
    input  logic       event_ready,
    output logic       event_valid,
    output logic [1:0] event_id,
    output logic       event_long,
    output logic       event_drop,
    output logic [2:0] mode_o
);

    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES);

    localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO  = '0;
    localparam logic [2:0]         MODE_LAST   = 3'(MODE_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_q,  state_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic [1:0]         lock_q,   lock_d;
    logic               valid_q,  valid_d;
    logic [1:0]         id_q,     id_d;
    logic               long_q,   long_d;
    logic               drop_q,   drop_d;
    logic [2:0]         mode_q,   mode_d;

    logic               gen;
    logic               gen_long;
    logic [1:0]         first_id;

    // Lowest set index; only meaningful when some button is pressed.
    always_comb begin
        first_id = 2'd3;
        if (button_i[0]) begin
            first_id = 2'd0;
        end else if (button_i[1]) begin
            first_id = 2'd1;
        end else if (button_i[2]) begin
            first_id = 2'd2;
        end
    end

    // Press classification FSM
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        lock_d   = lock_q;
        gen      = 1'b0;
        gen_long = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|button_i) begin
                    lock_d  = first_id;
                    timer_d = TIMER_ZERO;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Release is checked first so that a release coinciding
                // with the threshold still yields a short press.
                if (!button_i[lock_q]) begin
                    gen     = 1'b1;
                    state_d = ST_RELEASE;
                end else if (timer_q == LONG_LAST) begin
                    gen      = 1'b1;
                    gen_long = 1'b1;
                    timer_d  = TIMER_ZERO;
                    state_d  = ST_REPEAT;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_REPEAT: begin
                if (!button_i[lock_q]) begin
                    state_d = ST_RELEASE;
                end else if (timer_q == REPEAT_LAST) begin
                    gen      = 1'b1;
                    gen_long = 1'b1;
                    timer_d  = TIMER_ZERO;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_RELEASE: begin
                // Wait for every button to be released before re-arming.
                if (button_i == 4'b0000) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One-entry output buffer and mode stepping
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        long_d  = long_q;
        drop_d  = 1'b0;
        mode_d  = mode_q;
        if (gen) begin
            // Loading is allowed when empty or when the held entry is being
            // accepted in this same cycle.
            if (!valid_q || event_ready) begin
                valid_d = 1'b1;
                id_d    = lock_q;
                long_d  = gen_long;
            end else begin
                drop_d = 1'b1;
            end
            // The mode follows every generated event, dropped or not.
            case (lock_q)
                2'd0: mode_d = (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
                2'd1: mode_d = (mode_q == 3'd0) ? MODE_LAST : mode_q - 3'd1;
                2'd2: if (!gen_long) mode_d = 3'd0;
                default: mode_d = mode_q;
            endcase
        end else if (valid_q && event_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= TIMER_ZERO;
            lock_q  <= 2'd0;
            valid_q <= 1'b0;
            id_q    <= 2'd0;
            long_q  <= 1'b0;
            drop_q  <= 1'b0;
            mode_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lock_q  <= lock_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            long_q  <= long_d;
            drop_q  <= drop_d;
            mode_q  <= mode_d;
        end
    end

    assign event_valid = valid_q;
    assign event_id    = id_q;
    assign event_long  = long_q;
    assign event_drop  = drop_q;
    assign mode_o      = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_ctrl
// Description : Self-checking bench for button_ctrl. Directed press
//               scenarios followed by random button/ready traffic, checked
//               every cycle against a press-age based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_ctrl;

    localparam int L  = 8;
    localparam int R  = 4;
    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic       rdy = 1'b1;
    logic       event_valid;
    logic [1:0] event_id;
    logic       event_long;
    logic       event_drop;
    logic [2:0] mode_o;

    button_ctrl #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R),
        .MODE_COUNT   (MC)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button_i   (btn),
        .event_ready(rdy),
        .event_valid(event_valid),
        .event_id   (event_id),
        .event_long (event_long),
        .event_drop (event_drop),
        .mode_o     (mode_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observed event statistics (from DUT outputs)
    int ev_cnt   = 0;
    int long_cnt = 0;
    int drop_cnt = 0;
    int last_id  = 0;

    // Reference model: a press is described by its locked button and its
    // age in cycles since it was latched.
    bit m_busy, m_wait;
    int m_lock, m_age;
    bit m_valid, m_long, m_drop;
    int m_id, m_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_wait = 0; m_lock = 0; m_age = 0;
        m_valid = 0; m_long = 0; m_drop = 0; m_id = 0; m_mode = 0;
    endtask

    task automatic model_step(input logic [3:0] b, input logic r);
        bit ev  = 0;
        bit evl = 0;
        int eid = m_lock;
        if (m_busy) begin
            m_age++;
            if (!b[m_lock]) begin
                // Released within the first L cycles: short press.
                if (m_age <= L) ev = 1;
                m_busy = 0;
                m_wait = 1;
            end else if (m_age >= L && (m_age - L) % R == 0) begin
                ev = 1; evl = 1;
            end
        end else if (m_wait) begin
            if (b == 4'b0000) m_wait = 0;
        end else if (b != 4'b0000) begin
            m_busy = 1;
            m_age  = 0;
            m_lock = b[0] ? 0 : b[1] ? 1 : b[2] ? 2 : 3;
        end
        m_drop = 0;
        if (ev) begin
            case (eid)
                0: m_mode = (m_mode + 1) % MC;
                1: m_mode = (m_mode + MC - 1) % MC;
                2: if (!evl) m_mode = 0;
                default: ;
            endcase
            if (!m_valid || r) begin
                m_valid = 1; m_id = eid; m_long = evl;
            end else begin
                m_drop = 1;
            end
        end else if (m_valid && r) begin
            m_valid = 0;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
    task automatic step(input logic [3:0] b, input logic r);
        btn = b;
        rdy = r;
        @(posedge clk);
        model_step(b, r);
        #1;
        check("valid", 32'(event_valid), 32'(m_valid));
        check("id",    32'(event_id),    32'(m_id));
        check("long",  32'(event_long),  32'(m_long));
        check("drop",  32'(event_drop),  32'(m_drop));
        check("mode",  32'(mode_o),      32'(m_mode));
        if (event_valid && rdy) begin
            ev_cnt++;
            if (event_long) long_cnt++;
            last_id = int'(event_id);
        end
        if (event_drop) drop_cnt++;
    endtask

    task automatic steps(input logic [3:0] b, input logic r, input int n);
        for (int i = 0; i < n; i++) step(b, r);
    endtask

    task automatic zeros_check(input string tag);
        check({tag, "_valid"}, 32'(event_valid), 0);
        check({tag, "_id"},    32'(event_id),    0);
        check({tag, "_long"},  32'(event_long),  0);
        check({tag, "_drop"},  32'(event_drop),  0);
        check({tag, "_mode"},  32'(mode_o),      0);
    endtask

    // Asynchronous reset pulse, with button b held throughout.
    task automatic do_reset(input logic [3:0] b);
        btn = b;
        #2 rst_n = 1'b0;
        #1 zeros_check("rst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        ev_cnt = 0; long_cnt = 0; drop_cnt = 0;
    endtask

    initial begin
        model_reset();
        #12 zeros_check("por");
        @(negedge clk) rst_n = 1'b1;

        // Short press
        steps(4'b0001, 1, 3);
        steps(4'b0000, 1, 3);
        check("short_ev", ev_cnt, 1);
        check("short_long", long_cnt, 0);
        check("short_mode", 32'(mode_o), 1);

        // Long hold with auto-repeat: 3 long events, mode 0 -> 3
        do_reset(4'b0000);
        steps(4'b0001, 1, 20);
        steps(4'b0000, 1, 3);
        check("rep_ev", ev_cnt, 3);
        check("rep_long", long_cnt, 3);
        check("rep_mode", 32'(mode_o), 3);

        // Wrap and priority
        do_reset(4'b0000);
        steps(4'b0010, 1, 3);
        steps(4'b0000, 1, 2);
        check("wrap_mode", 32'(mode_o), 3);
        steps(4'b0011, 1, 3);
        steps(4'b0000, 1, 2);
        check("prio_id", last_id, 0);
        check("prio_mode", 32'(mode_o), 0);
        steps(4'b0010, 1, 2);
        steps(4'b0011, 1, 3);
        steps(4'b0000, 1, 2);
        check("ign_id", last_id, 1);
        check("ign_mode", 32'(mode_o), 3);

        // Backpressure: second short press is dropped
        do_reset(4'b0000);
        steps(4'b0001, 0, 3);
        steps(4'b0000, 0, 2);
        steps(4'b0001, 0, 3);
        steps(4'b0000, 0, 2);
        check("bp_drop", drop_cnt, 1);
        check("bp_valid", 32'(event_valid), 1);
        check("bp_mode", 32'(mode_o), 2);
        step(4'b0000, 1);
        check("bp_clear", 32'(event_valid), 0);

        // Release exactly when the hold timer reaches its last count
        do_reset(4'b0000);
        steps(4'b0001, 1, 8);
        steps(4'b0000, 1, 2);
        check("edge_ev", ev_cnt, 1);
        check("edge_long", long_cnt, 0);

        // Reset during repeat, button still held afterwards
        do_reset(4'b0000);
        steps(4'b0001, 1, 12);
        do_reset(4'b0001);
        steps(4'b0001, 1, 9);
        check("rehold_long", long_cnt, 1);
        steps(4'b0000, 1, 2);

        // Random traffic
        for (int s = 0; s < 300; s++) begin
            logic [3:0] b;
            int n;
            b = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            n = $urandom_range(1, 14);
            for (int k = 0; k < n; k++) step(b, ($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
